// File: rtl/sdm_pkg.sv
// Shared types and constants for the second-order sigma-delta bit generator.
// Optional dither (in sdm_loop2) is enabled by defining SDM_DITHER_EN.
package sdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sdm_state_e;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Full scale for a signed word of width din_w: 2^(din_w-1)
    function automatic logic signed [63:0] sdm_fs(input int din_w);
        return 64'sd1 <<< (din_w - 1);
    endfunction

    // Integrator clamp magnitude for width acc_w: 2^(acc_w-1)-1
    function automatic logic signed [63:0] sdm_sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/sdm_loop2.sv
// Two saturating integrators, 1-bit quantiser and optional quantiser dither.
// Define SDM_DITHER_EN to build the LFSR dither; otherwise it is absent.
module sdm_loop2
    import sdm_pkg::*;
#(
    parameter int DIN_W = 24,
    parameter int ACC_W = DIN_W + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [DIN_W-1:0] x,
    output logic                    qbit,
    output logic                    sat_hit
);

    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] FS  = SW'(sdm_fs(DIN_W));
    localparam logic signed [SW-1:0] LIM = SW'(sdm_sat_max(ACC_W));

    logic signed [ACC_W-1:0] i1, i2;
    logic signed [SW-1:0]    fb, s1, s2, c1, c2, qin;
    logic                    hit1, hit2;

    // Integrator sums with clamping; feedback follows the previous bit
    always_comb begin
        fb   = qbit ? FS : -FS;
        s1   = SW'(i1) + SW'(x) - fb;
        s2   = SW'(i2) + SW'(i1) - fb;
        c1   = s1;
        c2   = s2;
        hit1 = 1'b0;
        hit2 = 1'b0;
        if (s1 > LIM) begin
            c1   = LIM;
            hit1 = 1'b1;
        end else if (s1 < -LIM) begin
            c1   = -LIM;
            hit1 = 1'b1;
        end
        if (s2 > LIM) begin
            c2   = LIM;
            hit2 = 1'b1;
        end else if (s2 < -LIM) begin
            c2   = -LIM;
            hit2 = 1'b1;
        end
    end

    assign sat_hit = en & (hit1 | hit2);

`ifdef SDM_DITHER_EN
    localparam logic signed [SW-1:0] DITH = SW'(sdm_fs(DIN_W - 8));

    logic [15:0] lfsr;

    // Dither source steps only while modulating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    // Dither touches the quantiser decision only, never the integrator state
    always_comb begin
        qin = c2 + (lfsr[0] ? DITH : -DITH);
    end
`else
    // Quantiser sees the new second integrator value directly
    always_comb begin
        qin = c2;
    end
`endif

    // Update integrators when enabled; otherwise hold them and alternate the bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i1   <= '0;
            i2   <= '0;
            qbit <= 1'b0;
        end else if (en) begin
            i1   <= ACC_W'(c1);
            i2   <= ACC_W'(c2);
            qbit <= ~qin[SW-1];
        end else begin
            qbit <= ~qbit;
        end
    end

endmodule

// File: rtl/sdm_bit_gen.sv
// PCM to 1-bit second-order sigma-delta stream with one-deep sample buffer.
// SDM_DITHER_EN adds LFSR dither at the quantiser (see sdm_loop2).
module sdm_bit_gen
    import sdm_pkg::*;
#(
    parameter int DIN_W = 24,
    parameter int OSR   = 64,
    parameter int ACC_W = DIN_W + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_vld,
    output logic                    din_rdy,
    output logic                    bit_out,
    output logic                    bit_vld,
    output logic                    frame,
    output logic                    underrun,
    output logic                    sat
);

    localparam int PH_W = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    sdm_state_e              state, state_nx;
    logic [PH_W-1:0]         phase;
    logic signed [DIN_W-1:0] cur, nbuf;
    logic                    nbuf_full;
    logic                    run, load, xfer, sat_hit;

    // Handshake, period markers and next state
    always_comb begin
        run      = (state == RUN);
        load     = run && (phase == PH_LAST);
        din_rdy  = ~nbuf_full | load;
        xfer     = din_vld & din_rdy;
        bit_vld  = run;
        frame    = run && (phase == '0);
        underrun = load && !nbuf_full;
        state_nx = state;
        unique case (state)
            IDLE:    if (xfer) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Phase counter, sample buffering and sticky clip flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            cur       <= '0;
            nbuf      <= '0;
            nbuf_full <= 1'b0;
            sat       <= 1'b0;
        end else begin
            sat <= sat | sat_hit;
            if (run) begin
                phase <= load ? '0 : phase + 1'b1;
            end
            unique case (1'b1)
                !run: begin
                    if (xfer) cur <= din;
                end
                default: begin
                    if (load && nbuf_full) cur <= nbuf;
                    if (xfer) begin
                        nbuf      <= din;
                        nbuf_full <= 1'b1;
                    end else if (load) begin
                        nbuf_full <= 1'b0;
                    end
                end
            endcase
        end
    end

    sdm_loop2 #(
        .DIN_W(DIN_W),
        .ACC_W(ACC_W)
    ) u_loop (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .x      (cur),
        .qbit   (bit_out),
        .sat_hit(sat_hit)
    );

endmodule

// File: tb/tb_sdm_bit_gen.sv
// Directed bench for sdm_bit_gen: DC density table, bit-exact loop model,
// reset, backpressure and underrun sequences.
module tb_sdm_bit_gen;

    logic                clk;
    logic                rst;
    logic signed [23:0]  din;
    logic                din_vld;
    logic                din_rdy, bit_out, bit_vld, frame, underrun, sat;

    int n_cmp = 0;
    int n_bad = 0;

    sdm_bit_gen dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .din_rdy (din_rdy),
        .bit_out (bit_out),
        .bit_vld (bit_vld),
        .frame   (frame),
        .underrun(underrun),
        .sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic signed [23:0] din;
        int                 lo;
        int                 hi;
        logic               sat;
    } dc_vec_t;

    dc_vec_t vecs[6];

    localparam longint FS  = 64'sd1 <<< 23;
    localparam longint LIM = (64'sd1 <<< 27) - 1;

    longint mi1, mi2, mx, ms1, ms2;
    logic   mq;
    int     ones, e_bit, e_vld, e_rdy, e_fr, e_un, e_cur, n_un, nxf, sent;
    logic   rdy_s, exp_rdy, exp_un;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act,
                           input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        din_vld = 1'b0;
        din     = '0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic longint clamp(input longint v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    initial begin
        vecs[0] = '{24'sh000000, 2044, 2052, 1'b0};
        vecs[1] = '{24'sh400000, 3052, 3092, 1'b0};
        vecs[2] = '{24'shC00000, 1004, 1044, 1'b0};
        vecs[3] = '{24'sh200000, 2540, 2580, 1'b0};
        vecs[4] = '{24'shE00000, 1516, 1556, 1'b0};
        vecs[5] = '{24'sh7FFFFF, 4000, 4096, 1'b1};

        rst     = 1'b1;
        din     = '0;
        din_vld = 1'b0;

        // DC table: ones density, sticky clip flag, bit-exact loop model
        for (int v = 0; v < 6; v++) begin
            do_reset();
            din     = vecs[v].din;
            din_vld = 1'b1;
            mx      = longint'(vecs[v].din);
            mi1     = 0;
            mi2     = 0;
            mq      = 1'b0;
            ones    = 0;
            e_bit   = 0;
            e_vld   = 0;
            @(posedge clk);
            #1;
            mq = ~mq;
            if (bit_out !== mq) e_bit++;
            for (int k = 1; k <= 4096; k++) begin
                @(posedge clk);
                #1;
                ms1 = mi1 + mx - (mq ? FS : -FS);
                ms2 = mi2 + mi1 - (mq ? FS : -FS);
                mi1 = clamp(ms1);
                mi2 = clamp(ms2);
                mq  = (mi2 >= 0);
                if (bit_out !== mq) e_bit++;
                if (bit_vld !== 1'b1) e_vld++;
                ones += int'(bit_out);
            end
            chk_rng($sformatf("dc%0d_ones", v), ones, vecs[v].lo, vecs[v].hi);
            chk($sformatf("dc%0d_sat", v), sat, vecs[v].sat);
            chk($sformatf("dc%0d_vld_errs", v), e_vld, 0);
`ifndef SDM_DITHER_EN
            chk($sformatf("dc%0d_bit_errs", v), e_bit, 0);
`endif
        end

        // Asynchronous reset mid-run (sat set, buffer full)
        #2;
        rst = 1'b0;
        #1;
        chk("rst_bit_out", bit_out, 0);
        chk("rst_bit_vld", bit_vld, 0);
        chk("rst_frame", frame, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_sat", sat, 0);
        chk("rst_din_rdy", din_rdy, 1);
        din_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_bit%0d", k), bit_out, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("idle_vld%0d", k), bit_vld, 0);
        end

        // Backpressure: incrementing counter with din_vld held high
        do_reset();
        din     = 24'sd0;
        din_vld = 1'b1;
        e_rdy = 0; e_fr = 0; e_un = 0; e_cur = 0; nxf = 0;
        for (int c = 0; c <= 320; c++) begin
            exp_rdy = (c <= 1) || (c % 64 == 0);
            if (din_rdy !== exp_rdy) e_rdy++;
            if (frame !== (c % 64 == 1)) e_fr++;
            if (underrun !== 1'b0) e_un++;
            if (c % 64 == 1 && dut.cur !== 24'(c / 64)) e_cur++;
            rdy_s = din_rdy;
            @(posedge clk);
            #1;
            if (rdy_s) begin
                nxf++;
                din = 24'(nxf);
            end
        end
        chk("bp_rdy_errs", e_rdy, 0);
        chk("bp_frame_errs", e_fr, 0);
        chk("bp_underrun_errs", e_un, 0);
        chk("bp_cur_errs", e_cur, 0);
        chk("bp_xfers", nxf, 7);

        // Underrun: three samples then stop, last sample held
        do_reset();
        sent    = 0;
        din     = 24'sd100;
        din_vld = 1'b1;
        e_rdy = 0; e_fr = 0; e_un = 0; e_cur = 0; e_vld = 0; n_un = 0;
        for (int c = 0; c <= 330; c++) begin
            exp_rdy = (c <= 1) || (c == 64) || (c >= 128);
            exp_un  = (c == 192) || (c == 256) || (c == 320);
            if (din_rdy !== exp_rdy) e_rdy++;
            if (underrun !== exp_un) e_un++;
            if (frame !== (c % 64 == 1)) e_fr++;
            if (bit_vld !== (c >= 1)) e_vld++;
            if (c % 64 == 1 &&
                dut.cur !== 24'(100 + ((c / 64) > 2 ? 2 : (c / 64)))) e_cur++;
            n_un += int'(underrun);
            rdy_s = din_rdy & din_vld;
            @(posedge clk);
            #1;
            if (rdy_s) begin
                sent++;
                din = 24'(100 + sent);
                if (sent == 3) din_vld = 1'b0;
            end
        end
        chk("ur_rdy_errs", e_rdy, 0);
        chk("ur_underrun_errs", e_un, 0);
        chk("ur_frame_errs", e_fr, 0);
        chk("ur_vld_errs", e_vld, 0);
        chk("ur_cur_errs", e_cur, 0);
        chk("ur_pulses", n_un, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
